// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S/TDM serial audio transmitter.
package i2s_pkg;

   typedef enum logic {
      I2S_MODE = 1'b0,
      LJ_MODE  = 1'b1
   } i2s_mode_e;

   localparam int UNDERRUN_CNT_W = 16;

   function automatic int frame_bits(input int num_ch, input int slot_w);
      return num_ch * slot_w;
   endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: free-running count 0..BCLK_DIV-1, bclk high for the upper half,
// bit_tick on the last count so serial outputs update together with bclk falling.
module i2s_bclk_gen #(
   parameter int BCLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   output logic bclk_o,
   output logic bit_tick_o
);
   localparam int CNT_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BCLK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BCLK_DIV / 2);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             bclk_q, bclk_d;

   always_comb begin
      cnt_d  = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
      bclk_d = (cnt_d >= CNT_HALF);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         bclk_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         bclk_q <= bclk_d;
      end
   end

   assign bclk_o     = bclk_q;
   assign bit_tick_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/i2s_tdm_tx.sv
// N-channel I2S / left-justified TDM transmitter with a one-frame holding buffer
// and underrun detection (silence is sent whenever no frame is waiting).
module i2s_tdm_tx
   import i2s_pkg::*;
#(
   parameter int NUM_CH   = 2,
   parameter int SAMPLE_W = 24,
   parameter int SLOT_W   = 32,
   parameter int BCLK_DIV = 4,
   parameter int MODE     = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_CH*SAMPLE_W-1:0]   frame_i,
   input  logic                         valid_i,
   output logic                         ready_o,
   output logic                         bclk_o,
   output logic                         lrclk_o,
   output logic                         sdata_o,
   output logic                         frame_start_o,
   output logic                         underrun_o,
   output logic [UNDERRUN_CNT_W-1:0]    underrun_cnt_o
);
   localparam int FRAME_W    = NUM_CH * SAMPLE_W;
   localparam int FRAME_BITS = frame_bits(NUM_CH, SLOT_W);
   localparam int B_W        = $clog2(FRAME_BITS);
   localparam int CH_W       = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
   localparam int POS_W      = (SLOT_W > 2) ? $clog2(SLOT_W) : 1;
   localparam logic [B_W-1:0]   B_LAST   = B_W'(FRAME_BITS - 1);
   localparam logic [B_W-1:0]   B_HALF   = B_W'(FRAME_BITS / 2);
   localparam logic [POS_W-1:0] POS_LAST = POS_W'(SLOT_W - 1);
   localparam i2s_mode_e        MODE_E   = (MODE == 1) ? LJ_MODE : I2S_MODE;

   logic bit_tick;

   i2s_bclk_gen #(
      .BCLK_DIV (BCLK_DIV)
   ) u_bclk_gen (
      .clk        (clk),
      .rst_n      (rst_n),
      .bclk_o     (bclk_o),
      .bit_tick_o (bit_tick)
   );

   logic [B_W-1:0]            b_q, b_d;
   logic [CH_W-1:0]           slot_q, slot_d;
   logic [POS_W-1:0]          pos_q, pos_d;
   logic                      started_q, started_d;
   logic [FRAME_W-1:0]        frame_q, frame_d;
   logic [FRAME_W-1:0]        hold_q, hold_d;
   logic                      hold_full_q, hold_full_d;
   logic                      lrclk_q, lrclk_d;
   logic                      sdata_q, sdata_d;
   logic                      dly_q, dly_d;
   logic                      frame_start_q, frame_start_d;
   logic                      underrun_q, underrun_d;
   logic [UNDERRUN_CNT_W-1:0] ucnt_q, ucnt_d;

   logic                      accept;
   logic                      load;
   logic [SAMPLE_W-1:0]       sample_sel;
   logic [SAMPLE_W-1:0]       sample_shl;
   logic                      lj_bit;

   always_comb begin
      accept    = valid_i && !hold_full_q;
      // The very first tick after reset starts a frame just like a wrap does.
      load      = bit_tick && (!started_q || (b_q == B_LAST));
      started_d = started_q | bit_tick;

      b_d    = b_q;
      slot_d = slot_q;
      pos_d  = pos_q;
      if (load) begin
         b_d    = '0;
         slot_d = '0;
         pos_d  = '0;
      end else if (bit_tick) begin
         b_d = b_q + B_W'(1);
         if (pos_q == POS_LAST) begin
            pos_d  = '0;
            slot_d = slot_q + CH_W'(1);
         end else begin
            pos_d = pos_q + POS_W'(1);
         end
      end

      frame_d = frame_q;
      if (load) begin
         frame_d = hold_full_q ? hold_q : '0;
      end

      sample_sel = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (slot_d == CH_W'(k)) begin
            sample_sel = frame_d[k*SAMPLE_W +: SAMPLE_W];
         end
      end
      // Shifting past the sample width naturally yields the zero padding of the slot.
      sample_shl = sample_sel << pos_d;
      lj_bit     = sample_shl[SAMPLE_W-1];

      lrclk_d = lrclk_q;
      sdata_d = sdata_q;
      dly_d   = dly_q;
      if (bit_tick) begin
         lrclk_d = (b_d >= B_HALF);
         dly_d   = lj_bit;
         sdata_d = (MODE_E == LJ_MODE) ? lj_bit : dly_q;
      end

      hold_d      = accept ? frame_i : hold_q;
      hold_full_d = accept ? 1'b1 : (load ? 1'b0 : hold_full_q);

      frame_start_d = load;
      underrun_d    = load && !hold_full_q;
      ucnt_d        = ucnt_q;
      if (underrun_d && (ucnt_q != '1)) begin
         ucnt_d = ucnt_q + UNDERRUN_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_q           <= '0;
         slot_q        <= '0;
         pos_q         <= '0;
         started_q     <= 1'b0;
         frame_q       <= '0;
         hold_q        <= '0;
         hold_full_q   <= 1'b0;
         lrclk_q       <= 1'b0;
         sdata_q       <= 1'b0;
         dly_q         <= 1'b0;
         frame_start_q <= 1'b0;
         underrun_q    <= 1'b0;
         ucnt_q        <= '0;
      end else begin
         b_q           <= b_d;
         slot_q        <= slot_d;
         pos_q         <= pos_d;
         started_q     <= started_d;
         frame_q       <= frame_d;
         hold_q        <= hold_d;
         hold_full_q   <= hold_full_d;
         lrclk_q       <= lrclk_d;
         sdata_q       <= sdata_d;
         dly_q         <= dly_d;
         frame_start_q <= frame_start_d;
         underrun_q    <= underrun_d;
         ucnt_q        <= ucnt_d;
      end
   end

   assign ready_o        = ~hold_full_q;
   assign lrclk_o        = lrclk_q;
   assign sdata_o        = sdata_q;
   assign frame_start_o  = frame_start_q;
   assign underrun_o     = underrun_q;
   assign underrun_cnt_o = ucnt_q;

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// Scoreboard bench: three transmitter configurations share clock and reset; accepted
// frames are queued as expected bit streams and compared against the captured serial data.
module tb_i2s_tdm_tx;

   // instance 0: defaults (I2S), 1: left-justified, 2: 4ch x 16/16, BCLK_DIV=2, I2S
   localparam int BD  [3] = '{4, 4, 2};
   localparam int DLY [3] = '{1, 0, 1};

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [2:0]        vld;
   logic [63:0]       nxt_frame [3];
   logic [2:0]        rdy, bc, lr, sd, fs, ur;
   logic [2:0][15:0]  ucnt;

   always #5 clk = ~clk;

   i2s_tdm_tx u_dut_i2s (
      .clk (clk), .rst_n (rst_n), .frame_i (nxt_frame[0][47:0]), .valid_i (vld[0]),
      .ready_o (rdy[0]), .bclk_o (bc[0]), .lrclk_o (lr[0]), .sdata_o (sd[0]),
      .frame_start_o (fs[0]), .underrun_o (ur[0]), .underrun_cnt_o (ucnt[0])
   );

   i2s_tdm_tx #(.MODE(1)) u_dut_lj (
      .clk (clk), .rst_n (rst_n), .frame_i (nxt_frame[1][47:0]), .valid_i (vld[1]),
      .ready_o (rdy[1]), .bclk_o (bc[1]), .lrclk_o (lr[1]), .sdata_o (sd[1]),
      .frame_start_o (fs[1]), .underrun_o (ur[1]), .underrun_cnt_o (ucnt[1])
   );

   i2s_tdm_tx #(.NUM_CH(4), .SAMPLE_W(16), .SLOT_W(16), .BCLK_DIV(2), .MODE(0)) u_dut_tdm (
      .clk (clk), .rst_n (rst_n), .frame_i (nxt_frame[2]), .valid_i (vld[2]),
      .ready_o (rdy[2]), .bclk_o (bc[2]), .lrclk_o (lr[2]), .sdata_o (sd[2]),
      .frame_start_o (fs[2]), .underrun_o (ur[2]), .underrun_cnt_o (ucnt[2])
   );

   int          n_vec = 0;
   int          n_bad = 0;
   int          cyc = 0;
   logic [2:0]  prod_en = '0;
   logic [2:0]  acc_pend;
   logic [63:0] acc_q  [3][$];
   logic [63:0] pend_q [3][$];
   logic [63:0] cur [3];
   logic [63:0] lr_vec [3];
   logic [15:0] exp_cnt [3];
   int          r_cnt [3];
   int          last_fs [3];
   int          last_rise [3];
   int          n_frm [3];
   logic [2:0]  started;
   logic [2:0]  bc_prev;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] to_stream(input int i, input logic [63:0] f);
      if (i == 2) return {f[15:0], f[31:16], f[47:32], f[63:48]};
      return {f[23:0], 8'h00, f[47:24], 8'h00};
   endfunction

   function automatic logic [63:0] new_frame(input int i);
      if (i == 2) return {32'($urandom), 32'($urandom)};
      return {16'h0000, 16'($urandom), 32'($urandom)};
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 3; i++) begin
         acc_q[i].delete();
         pend_q[i].delete();
         cur[i]       = '0;
         lr_vec[i]    = '0;
         exp_cnt[i]   = '0;
         r_cnt[i]     = 0;
         last_fs[i]   = -1;
         last_rise[i] = -1;
      end
      acc_pend = '0;
      started  = '0;
      bc_prev  = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      clear_model();
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         vld[i]      = prod_en[i];
         acc_pend[i] = vld[i] && rdy[i];
      end
      rst_n = 1'b1;
   endtask

   // One clock of monitoring and driving, performed at the falling clk edge.
   task automatic step();
      bit          exp_ur;
      logic [63:0] e;
      int          r;
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 3; i++) begin
         if (fs[i]) begin
            exp_ur = (acc_q[i].size() == 0);
            if (exp_ur) begin
               e = '0;
               if (exp_cnt[i] != 16'hFFFF) exp_cnt[i]++;
            end else begin
               e = acc_q[i].pop_front();
               chk($sformatf("ready_at_load[%0d]", i), 64'(rdy[i]), 64'd1);
            end
            pend_q[i].push_back(e);
            chk($sformatf("underrun[%0d]", i), 64'(ur[i]), 64'(exp_ur));
            chk($sformatf("underrun_cnt[%0d]", i), 64'(ucnt[i]), 64'(exp_cnt[i]));
            if (last_fs[i] >= 0)
               chk($sformatf("frame_period[%0d]", i), 64'(cyc - last_fs[i]), 64'(64 * BD[i]));
            last_fs[i] = cyc;
            r_cnt[i]   = 0;
            started[i] = 1'b1;
         end else if (ur[i]) begin
            chk($sformatf("stray_underrun[%0d]", i), 64'(ur[i]), 64'd0);
         end

         if (bc[i] && !bc_prev[i]) begin
            if (last_rise[i] >= 0)
               chk($sformatf("bclk_period[%0d]", i), 64'(cyc - last_rise[i]), 64'(BD[i]));
            last_rise[i] = cyc;
            if (started[i]) begin
               r = r_cnt[i];
               lr_vec[i] = {lr_vec[i][62:0], lr[i]};
               if (r == 63)
                  chk($sformatf("lrclk_frame[%0d]", i), lr_vec[i], 64'h0000_0000_FFFF_FFFF);
               if (DLY[i] == 1 && r == 0 && pend_q[i].size() < 2) begin
                  chk($sformatf("first_bit[%0d]", i), 64'(sd[i]), 64'd0);
               end else begin
                  cur[i] = {cur[i][62:0], sd[i]};
                  if (((DLY[i] == 1) && r == 0) || ((DLY[i] == 0) && r == 63)) begin
                     if (pend_q[i].size() > 0) begin
                        e = pend_q[i].pop_front();
                        n_frm[i]++;
                        $display("inst %0d frame %0d stream %h expect %h", i, n_frm[i], cur[i], e);
                        chk($sformatf("frame_data[%0d]", i), cur[i], e);
                     end
                  end
               end
               r_cnt[i]++;
            end
         end
         bc_prev[i] = bc[i];

         if (acc_pend[i]) begin
            acc_q[i].push_back(to_stream(i, nxt_frame[i]));
            nxt_frame[i] = new_frame(i);
         end
         vld[i]      = prod_en[i];
         acc_pend[i] = vld[i] && rdy[i];
      end
   endtask

   initial begin
      int w;
      vld = '0;
      n_frm = '{0, 0, 0};
      for (int i = 0; i < 3; i++) nxt_frame[i] = '0;
      clear_model();

      // Idle producer: three silent frames, each an underrun.
      do_reset();
      repeat (700) step();
      chk("idle_underrun_cnt", 64'(ucnt[0]), 64'd3);

      // Frame presented before the first load, then valid held high.
      nxt_frame[0] = {16'h0000, 24'h3C3C3C, 24'hA5A5A5};
      nxt_frame[1] = {16'h0000, 24'h3C3C3C, 24'hA5A5A5};
      nxt_frame[2] = {16'h7FFE, 16'hFFFF, 16'h0001, 16'h8001};
      prod_en = '1;
      do_reset();
      repeat (1600) step();

      // Producer stall: silence repeats, then streaming resumes.
      prod_en = '0;
      repeat (700) step();
      prod_en = '1;
      repeat (800) step();

      // Asynchronous reset at bit 40 of a frame with the holding buffer full.
      w = 0;
      while (!fs[0] && w < 600) begin
         step();
         w++;
      end
      chk("frame_start_wait", 64'(fs[0]), 64'd1);
      repeat (40 * 4 + 1) step();
      chk("hold_full_before_reset", 64'(rdy[0]), 64'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_bclk[%0d]", i), 64'(bc[i]), 64'd0);
         chk($sformatf("rst_lrclk[%0d]", i), 64'(lr[i]), 64'd0);
         chk($sformatf("rst_sdata[%0d]", i), 64'(sd[i]), 64'd0);
         chk($sformatf("rst_ready[%0d]", i), 64'(rdy[i]), 64'd1);
         chk($sformatf("rst_fstart[%0d]", i), 64'(fs[i]), 64'd0);
         chk($sformatf("rst_underrun[%0d]", i), 64'(ur[i]), 64'd0);
         chk($sformatf("rst_ucnt[%0d]", i), 64'(ucnt[i]), 64'd0);
      end
      clear_model();
      prod_en = '0;
      vld = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (200) step();
      chk("post_reset_ucnt", 64'(ucnt[0]), 64'd1);
      prod_en = '1;
      repeat (800) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
